qam_burst_modulator: RTL and testbench
======================================

Name: qam_burst_modulator

Overview:
- Parametrised successor to the fixed 4-point burst modulator: same carrier-LUT interface, symbol-rate phase counter and burst/guard framing.
- Adds runtime QPSK / 16-QAM mode, a valid/ready symbol input, configurable samples-per-symbol and burst/guard lengths, and a widened output that cannot overflow.
- Sits between the channel encoder (symbol source) and the DAC path; phase_idx addresses the shared sin/cos LUT.

Parameters:
- DW, 9, signed width of cos_in/sin_in.
- SPS_W, 7, log2 samples per symbol; phase_idx wraps at 2^SPS_W-1.
- BURST_SYMS, 32, symbols per burst (>=1).
- GUARD_SYMS, 31, silent symbol periods after each burst (>=0).
- OUT_W, DW+3, signed width of mod_out; must be >= DW+3.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = QPSK, 1 = 16-QAM; sampled only at burst start.
- sym_in  in  4  symbol; QPSK uses [1:0], 16-QAM uses [3:0].
- sym_valid  in  1  sym_in valid.
- sym_ready  out  1  block accepts a symbol this cycle.
- cos_in  in  DW  signed carrier cos sample for the current phase_idx.
- sin_in  in  DW  signed carrier sin sample for the current phase_idx.
- phase_idx  out  SPS_W  sample index within the symbol; LUT address.
- mod_out  out  OUT_W  signed modulated sample (registered).
- burst_active  out  1  high in BURST state.
- underrun  out  1  one-cycle pulse: symbol slot missed inside a burst.

Behaviour:
- Reset (async, reset=0): phase_idx=0, mod_out=0, state=IDLE, symbol count=0, guard count=0, I=Q=0, burst_mode=0, underrun=0. Deassertion takes effect on the next clk edge. Reset mid-burst aborts the burst immediately; no partial guard.
- phase_idx increments every cycle in all states and wraps 2^SPS_W-1 -> 0. A "slot boundary" is a cycle with phase_idx==0.
- sym_ready = (phase_idx==0) && (state is IDLE or BURST). It is combinational, does not depend on sym_valid, and is low in GUARD. A transfer occurs when sym_valid && sym_ready.
- States:
  - IDLE: mod_out=0. On a transfer: latch mode into burst_mode, map the symbol, count=1, go to BURST.
  - BURST:
    - At each boundary with a transfer: map the symbol and increment count.
    - At a boundary with no transfer: I=Q=0 (silent slot), pulse underrun, increment count.
    - Missed slots count toward BURST_SYMS.
    - When a slot boundary is reached with count==BURST_SYMS, no symbol is accepted in that cycle. Go to GUARD (or to IDLE if GUARD_SYMS==0), guard count=0, I=Q=0.
  - GUARD: mod_out=0. Increment guard count at each boundary. When it reaches GUARD_SYMS, move to IDLE at that same boundary. IDLE may accept a symbol at the next boundary, not the same one.
- Mapping (sub-module):
  - QPSK: I = sym[1] ? -1 : +1; Q = sym[0] ? -1 : +1.
  - 16-QAM, Gray coded, I from sym[3:2] and Q from sym[1:0]: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
  - I/Q held in 3-bit signed registers.
- Output: at each edge, mod_out <= I_eff*cos_in - Q_eff*sin_in.
  - Operands are sign-extended to OUT_W; no saturation or truncation is needed.
  - I_eff/Q_eff are the newly mapped values on an accepting boundary cycle, otherwise the held values.
  - Latency: exactly 1 cycle from cos_in/sin_in to mod_out.
- mode changes mid-burst are ignored until the next IDLE->BURST transition.
- sym_valid held high in GUARD has no effect; the data is not consumed.

Decomposition:
- Shared package qam_pkg holds:
  - state enum {IDLE, BURST, GUARD};
  - level constants L_M3, L_M1, L_P1, L_P3;
  - mode constants MODE_QPSK, MODE_16QAM;
  - the Gray-map function.
- One combinational sub-module, qam_symbol_mapper (mode, sym -> I, Q), reused by the demodulator team's reference model.

Test Plan:
- Reset/idle: reset low 5 cycles, then sym_valid=0 for 300 cycles -> mod_out=0, burst_active=0, phase_idx counts 0..127 and wraps; sym_ready high only at phase 0.
- QPSK burst: mode=0, sym=2'b00 always valid, cos_in=100, sin_in=40 constant -> mod_out=60 one cycle after acceptance. After 32 symbols, 31*128 cycles of 0, then a new burst starts.
- 16-QAM corners: mode=1, sym=4'b1010, cos=255, sin=-256 -> mod_out=3*255-3*(-256)=1533. sym=4'b0000 -> -1533. No overflow at OUT_W=12.
- Underrun: drop sym_valid for slot 5 of a burst -> that 128-cycle slot is 0, underrun pulses once at its boundary, and the burst still ends after 32 slots.
- Mode/guard handshake: toggle mode mid-burst -> constellation is unchanged until the next burst; sym_valid held high in GUARD -> sym_ready=0 and no symbol is consumed.
- Reset mid-burst: assert reset at symbol 10, phase 60 -> all outputs 0 asynchronously; after release, IDLE and a clean restart at phase 0.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and constellation helpers for the QAM burst modulator and its
// symbol mapper (also used by the demodulator reference model).
package qam_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam logic signed [2:0] L_M3 = -3'sd3;
  localparam logic signed [2:0] L_M1 = -3'sd1;
  localparam logic signed [2:0] L_P1 = 3'sd1;
  localparam logic signed [2:0] L_P3 = 3'sd3;

  localparam logic MODE_QPSK  = 1'b0;
  localparam logic MODE_16QAM = 1'b1;

  // Gray-coded 4-level axis: adjacent levels differ in one bit.
  function automatic logic signed [2:0] gray_level(input logic [1:0] bits);
    logic signed [2:0] lvl;
    case (bits)
      2'b00:   lvl = L_M3;
      2'b01:   lvl = L_M1;
      2'b11:   lvl = L_P1;
      default: lvl = L_P3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam_symbol_mapper.sv
// Combinational symbol-to-constellation mapper: QPSK on sym[1:0] or Gray-coded
// 16-QAM with I from sym[3:2] and Q from sym[1:0].
module qam_symbol_mapper
  import qam_pkg::*;
(
  input  logic              mode_i,
  input  logic [3:0]        sym_i,
  output logic signed [2:0] i_o,
  output logic signed [2:0] q_o
);

  always_comb begin
    if (mode_i == MODE_QPSK) begin
      i_o = sym_i[1] ? L_M1 : L_P1;
      q_o = sym_i[0] ? L_M1 : L_P1;
    end else begin
      i_o = gray_level(sym_i[3:2]);
      q_o = gray_level(sym_i[1:0]);
    end
  end

endmodule

// File: rtl/qam_burst_modulator.sv
// Burst-framed QPSK/16-QAM modulator: one symbol per 2^SPS_W samples, mixes the
// held I/Q levels with the shared carrier LUT, then inserts guard periods.
//
// state | meaning
// IDLE  | silent, waiting for a symbol at a slot boundary
// BURST | emitting BURST_SYMS symbol slots (missed slots are silent + underrun)
// GUARD | silent for GUARD_SYMS slots, input not consumed
module qam_burst_modulator
  import qam_pkg::*;
#(
  parameter int DW         = 9,
  parameter int SPS_W      = 7,
  parameter int BURST_SYMS = 32,
  parameter int GUARD_SYMS = 31,
  parameter int OUT_W      = DW + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [3:0]              sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic signed [DW-1:0]    cos_in,
  input  logic signed [DW-1:0]    sin_in,
  output logic [SPS_W-1:0]        phase_idx,
  output logic signed [OUT_W-1:0] mod_out,
  output logic                    burst_active,
  output logic                    underrun
);

  localparam int CNT_W  = $clog2(BURST_SYMS + 1);
  localparam int GCNT_W = (GUARD_SYMS > 0) ? $clog2(GUARD_SYMS + 1) : 1;
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_SYMS);
  localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_SYMS);

  state_e                    state_q;
  logic [SPS_W-1:0]          phase_q;
  logic [CNT_W-1:0]          sym_cnt_q;
  logic [GCNT_W-1:0]         guard_cnt_q;
  logic [GCNT_W-1:0]         guard_cnt_d;
  logic                      burst_mode_q;
  logic signed [2:0]         i_q, q_q;
  logic signed [OUT_W-1:0]   mod_out_q;
  logic                      underrun_q;

  logic                      boundary, burst_done, transfer, map_mode;
  logic signed [2:0]         i_map, q_map, i_eff, q_eff;
  logic signed [OUT_W-1:0]   i_ext, q_ext, cos_ext, sin_ext, mod_d;

  assign boundary   = (phase_q == '0);
  assign burst_done = (state_q == BURST) && (sym_cnt_q == BURST_LAST);
  // The closing boundary of a burst never takes a symbol, so ready stays low there.
  assign sym_ready  = boundary && ((state_q == IDLE) || ((state_q == BURST) && !burst_done));
  assign transfer   = sym_valid && sym_ready;
  assign map_mode   = (state_q == IDLE) ? mode : burst_mode_q;
  assign guard_cnt_d = guard_cnt_q + GCNT_W'(1);

  qam_symbol_mapper u_mapper (
    .mode_i (map_mode),
    .sym_i  (sym_in),
    .i_o    (i_map),
    .q_o    (q_map)
  );

  always_comb begin
    i_eff = (state_q == BURST) ? i_q : 3'sd0;
    q_eff = (state_q == BURST) ? q_q : 3'sd0;
    if (transfer) begin
      i_eff = i_map;
      q_eff = q_map;
    end else if (boundary) begin
      i_eff = 3'sd0;
      q_eff = 3'sd0;
    end
  end

  // OUT_W >= DW+3 holds |3*cos| + |3*sin| exactly, so no saturation is needed.
  assign i_ext   = {{(OUT_W-3){i_eff[2]}}, i_eff};
  assign q_ext   = {{(OUT_W-3){q_eff[2]}}, q_eff};
  assign cos_ext = {{(OUT_W-DW){cos_in[DW-1]}}, cos_in};
  assign sin_ext = {{(OUT_W-DW){sin_in[DW-1]}}, sin_in};
  assign mod_d   = (i_ext * cos_ext) - (q_ext * sin_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      sym_cnt_q    <= '0;
      guard_cnt_q  <= '0;
      burst_mode_q <= MODE_QPSK;
      i_q          <= 3'sd0;
      q_q          <= 3'sd0;
      mod_out_q    <= '0;
      underrun_q   <= 1'b0;
    end else begin
      phase_q    <= phase_q + SPS_W'(1);
      mod_out_q  <= mod_d;
      i_q        <= i_eff;
      q_q        <= q_eff;
      underrun_q <= 1'b0;
      if (boundary) begin
        case (state_q)
          IDLE: begin
            if (transfer) begin
              burst_mode_q <= mode;
              sym_cnt_q    <= CNT_W'(1);
              state_q      <= BURST;
            end
          end
          BURST: begin
            if (burst_done) begin
              sym_cnt_q   <= '0;
              guard_cnt_q <= '0;
              state_q     <= (GUARD_SYMS == 0) ? IDLE : GUARD;
            end else begin
              sym_cnt_q <= sym_cnt_q + CNT_W'(1);
              if (!transfer) underrun_q <= 1'b1;
            end
          end
          GUARD: begin
            guard_cnt_q <= guard_cnt_d;
            if (guard_cnt_d == GUARD_LAST) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign phase_idx    = phase_q;
  assign mod_out      = mod_out_q;
  assign burst_active = (state_q == BURST);
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_qam_burst_modulator.sv
// Scoreboard bench for qam_burst_modulator: the driver queues the hand-computed
// sample for each symbol it offers, a monitor pops one per observed handshake.
module tb_qam_burst_modulator;

  localparam int DW = 9, SPS_W = 7, BURST_SYMS = 32, GUARD_SYMS = 31, OUT_W = DW + 3;
  localparam int SLOT = 1 << SPS_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    mode;
  logic [3:0]              sym_in;
  logic                    sym_valid;
  logic                    sym_ready;
  logic signed [DW-1:0]    cos_in, sin_in;
  logic [SPS_W-1:0]        phase_idx;
  logic signed [OUT_W-1:0] mod_out;
  logic                    burst_active;
  logic                    underrun;

  int errors = 0;
  int checks = 0;
  logic signed [OUT_W-1:0] exp_q[$];
  logic [3:0]              pat_sym [4];
  logic signed [OUT_W-1:0] pat_exp [4];

  qam_burst_modulator #(
    .DW(DW), .SPS_W(SPS_W), .BURST_SYMS(BURST_SYMS), .GUARD_SYMS(GUARD_SYMS), .OUT_W(OUT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .cos_in       (cos_in),
    .sin_in       (sin_in),
    .phase_idx    (phase_idx),
    .mod_out      (mod_out),
    .burst_active (burst_active),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen before an edge must show its sample after that edge.
  initial begin
    logic pend;
    logic signed [OUT_W-1:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: symbol consumed with nothing expected, mod_out=%0d (t=%0t)", mod_out, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_mod_out", mod_out, e);
          end
        end
        pend = sym_valid && sym_ready;
      end
    end
  end

  // Entered at a phase-0 cycle; offers symbols for nslots slots.
  task automatic run_burst(input logic m, input logic m_mid, input int drop, input int abort_at, input int nslots);
    mode = m;
    for (int k = 0; k < nslots; k++) begin
      chk("slot_phase", phase_idx, 0);
      chk("slot_ready", sym_ready, 1);
      sym_valid = (k != drop);
      sym_in    = pat_sym[k % 4];
      if (k != drop) exp_q.push_back(pat_exp[k % 4]);
      if (k == 3) mode = m_mid;
      step();
      sym_valid = 1'b0;
      chk("burst_active", burst_active, 1);
      chk("underrun_pulse", underrun, (k == drop) ? 1 : 0);
      repeat (59) step();
      if (k == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_mod_out", mod_out, 0);
        chk("rst_phase", phase_idx, 0);
        chk("rst_active", burst_active, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_sb_empty", exp_q.size(), 0);
        return;
      end
      chk("slot_hold", mod_out, (k == drop) ? 0 : pat_exp[k % 4]);
      chk("underrun_once", underrun, 0);
      repeat (SLOT - 60) step();
    end
  endtask

  // Entered at the closing boundary of a burst; holds sym_valid high throughout.
  task automatic guard_phase();
    int bad;
    chk("end_ready", sym_ready, 0);
    chk("end_active", burst_active, 1);
    sym_valid = 1'b1;
    sym_in    = 4'b1010;
    for (int g = 1; g <= GUARD_SYMS + 1; g++) begin
      bad = 0;
      repeat (SLOT) begin
        step();
        if (mod_out !== '0 || burst_active !== 1'b0 || underrun !== 1'b0) bad++;
      end
      chk("guard_silent", bad, 0);
      chk("guard_ready", sym_ready, (g == GUARD_SYMS + 1) ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; sym_in = 4'h0; sym_valid = 1'b0; cos_in = '0; sin_in = '0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_mod_out", mod_out, 0);
    chk("async_rst_phase", phase_idx, 0);
    chk("async_rst_active", burst_active, 0);
    repeat (5) step();
    chk("rst_hold_phase", phase_idx, 0);
    reset = 1'b1;

    // Idle: phase free-runs, ready only at phase 0, output silent.
    for (int i = 1; i <= 300; i++) begin
      step();
      chk("idle_phase", phase_idx, i % SLOT);
      chk("idle_ready", sym_ready, (i % SLOT == 0) ? 1 : 0);
      chk("idle_mod_out", mod_out, 0);
      chk("idle_active", burst_active, 0);
    end
    repeat (SLOT - (300 % SLOT)) step();

    // QPSK burst, cos=100 sin=40.
    cos_in = 9'sd100; sin_in = 9'sd40;
    pat_sym[0] = 4'b0000; pat_exp[0] = 12'sd60;
    pat_sym[1] = 4'b0011; pat_exp[1] = -12'sd60;
    pat_sym[2] = 4'b0001; pat_exp[2] = 12'sd140;
    pat_sym[3] = 4'b0010; pat_exp[3] = -12'sd140;
    run_burst(1'b0, 1'b0, -1, -1, BURST_SYMS);
    guard_phase();

    // 16-QAM corners, underrun at slot 5, mode toggled to QPSK mid-burst.
    cos_in = 9'sd255; sin_in = -9'sd256;
    pat_sym[0] = 4'b1010; pat_exp[0] = 12'sd1533;
    pat_sym[1] = 4'b0000; pat_exp[1] = -12'sd1533;
    pat_sym[2] = 4'b0111; pat_exp[2] = 12'sd1;
    pat_sym[3] = 4'b1101; pat_exp[3] = -12'sd1;
    run_burst(1'b1, 1'b0, 5, -1, BURST_SYMS);
    guard_phase();

    // Same symbols in QPSK; mode toggled to 16-QAM mid-burst must be ignored.
    pat_exp[0] = 12'sd1;
    pat_exp[1] = 12'sd511;
    pat_exp[2] = -12'sd511;
    pat_exp[3] = -12'sd1;
    run_burst(1'b0, 1'b1, -1, -1, BURST_SYMS);
    guard_phase();

    // 16-QAM burst aborted by reset at symbol 10, phase 60.
    pat_exp[0] = 12'sd1533;
    pat_exp[1] = -12'sd1533;
    pat_exp[2] = 12'sd1;
    pat_exp[3] = -12'sd1;
    run_burst(1'b1, 1'b1, -1, 10, BURST_SYMS);
    repeat (3) step();
    chk("rst_hold_phase2", phase_idx, 0);
    chk("rst_hold_mod_out", mod_out, 0);
    reset = 1'b1;
    step();
    chk("restart_phase", phase_idx, 1);
    chk("restart_active", burst_active, 0);
    chk("restart_mod_out", mod_out, 0);
    repeat (SLOT - 1) step();
    run_burst(1'b1, 1'b1, -1, -1, 3);

    repeat (2) step();
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
